// File: rtl/image_sdram_writer_pkg.sv
// Shared types and sizes for the image SDRAM writer.
//   IMAGE_BYTES : byte size of the image region addressed by the loader
//   BYTE_AW     : loader byte address width
//   SD_AW/SD_DW : SDRAM word address / data widths
//   ENTRY_W     : FIFO entry width, {word address, word data}
package image_sdram_writer_pkg;

   localparam int unsigned IMAGE_BYTES = 32'd1 << 26;
   localparam int          BYTE_AW     = $clog2(IMAGE_BYTES);
   localparam int          SD_AW       = BYTE_AW - 1;
   localparam int          SD_DW       = 16;
   localparam int          ENTRY_W     = SD_AW + SD_DW;

   typedef enum logic [0:0] {
      DRAIN_IDLE = 1'b0,
      DRAIN_REQ  = 1'b1
   } drain_state_t;

   // Loader byte address -> 16-bit word address.
   function automatic logic [SD_AW-1:0] word_addr(input logic [BYTE_AW-1:0] byte_addr);
      return byte_addr[BYTE_AW-1:1];
   endfunction

endpackage

// File: rtl/image_sdram_writer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, reset_n : clock, synchronous active-low reset (clears pointers only)
//   push, din    : write request and data; dropped when full unless popping
//   pop          : consume head; ignored when empty
//   dout         : current head entry (valid while !empty)
//   full, empty  : occupancy flags
// DEPTH must be a power of two, minimum 2.
module sync_fifo
   import image_sdram_writer_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int           AW        = $clog2(DEPTH);
   localparam logic [AW:0]  DEPTH_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so push while full is accepted.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/image_sdram_writer.sv
// Repacks the ROM loader byte stream of the image region into 16-bit
// little-endian words, buffers them and writes them to SDRAM.
//   clk, reset_n      : clock, synchronous active-low reset
//   image_download    : loader is streaming the image region
//   wr_8bit           : one-cycle byte strobe
//   addr_8bit         : byte address relative to image start
//   data_8bit         : byte data
//   sd_wr             : SDRAM write request, held until sd_ack
//   sd_addr, sd_data  : SDRAM word address / data, stable while sd_wr
//   sd_ack            : one-cycle acknowledge
//   busy              : partial word, buffered word or request outstanding
//   overflow          : sticky, a word was dropped
//   done              : one-cycle pulse once a download has fully drained
//
// Drain FSM
//   state      | meaning
//   DRAIN_IDLE | no request; loads FIFO head into sd_addr/sd_data when available
//   DRAIN_REQ  | sd_wr asserted, outputs held until sd_ack
module image_sdram_writer
   import image_sdram_writer_pkg::*;
#(
   parameter int unsigned      FIFO_DEPTH = 8,
   parameter logic [SD_AW-1:0] SDRAM_BASE = 25'h0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               image_download,
   input  logic               wr_8bit,
   input  logic [BYTE_AW-1:0] addr_8bit,
   input  logic [7:0]         data_8bit,
   output logic               sd_wr,
   output logic [SD_AW-1:0]   sd_addr,
   output logic [SD_DW-1:0]   sd_data,
   input  logic               sd_ack,
   output logic               busy,
   output logic               overflow,
   output logic               done
);

   logic               accept;
   logic               is_odd;
   logic               dl_q;
   logic               dl_fall;
   logic [SD_AW-1:0]   wa;

   logic               pending, pending_n;
   logic [7:0]         low, low_n;
   logic [SD_AW-1:0]   pend_wa, pend_wa_n;

   logic               p1_v, p2_v;
   logic [SD_DW-1:0]   p1_d, p2_d;
   logic [SD_AW-1:0]   p1_wa, p2_wa;

   logic               push_v, slot_v;
   logic [SD_DW-1:0]   push_d, slot_d;
   logic [SD_AW-1:0]   push_wa, slot_wa;

   logic [SD_AW-1:0]   entry_addr;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;

   drain_state_t       state, state_n;
   logic               seen;

   assign accept  = wr_8bit & image_download;
   assign is_odd  = addr_8bit[0];
   assign wa      = word_addr(addr_8bit);
   assign dl_fall = dl_q & ~image_download;

   // Packer: decides up to two words per accepted byte. p1 goes out on the
   // next edge, p2 (odd byte landing on a different pending word) one later.
   always_comb begin
      p1_v      = 1'b0;
      p1_d      = '0;
      p1_wa     = '0;
      p2_v      = 1'b0;
      p2_d      = '0;
      p2_wa     = '0;
      pending_n = pending;
      low_n     = low;
      pend_wa_n = pend_wa;
      if (accept) begin
         if (!is_odd) begin
            if (pending) begin
               p1_v  = 1'b1;
               p1_d  = {8'h00, low};
               p1_wa = pend_wa;
            end
            pending_n = 1'b1;
            low_n     = data_8bit;
            pend_wa_n = wa;
         end else if (pending && (pend_wa == wa)) begin
            p1_v      = 1'b1;
            p1_d      = {data_8bit, low};
            p1_wa     = wa;
            pending_n = 1'b0;
         end else if (pending) begin
            p1_v      = 1'b1;
            p1_d      = {8'h00, low};
            p1_wa     = pend_wa;
            p2_v      = 1'b1;
            p2_d      = {data_8bit, 8'h00};
            p2_wa     = wa;
            pending_n = 1'b0;
         end else begin
            p1_v  = 1'b1;
            p1_d  = {data_8bit, 8'h00};
            p1_wa = wa;
         end
      end else if (dl_fall && pending) begin
         p1_v      = 1'b1;
         p1_d      = {8'h00, low};
         p1_wa     = pend_wa;
         pending_n = 1'b0;
      end
   end

   // A queued second-slot word wins over a new first-slot word; the new one
   // is lost and flagged through overflow.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dl_q    <= 1'b0;
         pending <= 1'b0;
         low     <= '0;
         pend_wa <= '0;
         push_v  <= 1'b0;
         push_d  <= '0;
         push_wa <= '0;
         slot_v  <= 1'b0;
         slot_d  <= '0;
         slot_wa <= '0;
      end else begin
         dl_q    <= image_download;
         pending <= pending_n;
         low     <= low_n;
         pend_wa <= pend_wa_n;
         if (slot_v) begin
            push_v  <= 1'b1;
            push_d  <= slot_d;
            push_wa <= slot_wa;
            slot_v  <= 1'b0;
         end else begin
            push_v  <= p1_v;
            push_d  <= p1_d;
            push_wa <= p1_wa;
            slot_v  <= p2_v;
            slot_d  <= p2_d;
            slot_wa <= p2_wa;
         end
      end
   end

   assign entry_addr = SDRAM_BASE + push_wa;
   assign fifo_din   = {entry_addr, push_d};

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_v),
      .din     (fifo_din),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The head is popped as it is copied into the request registers, so the
   // word under request no longer occupies a FIFO slot and the write path
   // holds FIFO_DEPTH + 1 words in total.
   always_comb begin
      state_n  = state;
      fifo_pop = 1'b0;
      case (state)
         DRAIN_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_n  = DRAIN_REQ;
            end
         end
         DRAIN_REQ: begin
            if (sd_ack) begin
               state_n = DRAIN_IDLE;
            end
         end
         default: state_n = DRAIN_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= DRAIN_IDLE;
         sd_addr <= '0;
         sd_data <= '0;
      end else begin
         state <= state_n;
         if (fifo_pop) begin
            {sd_addr, sd_data} <= fifo_dout;
         end
      end
   end

   assign sd_wr = (state == DRAIN_REQ);
   assign busy  = pending | push_v | slot_v | ~fifo_empty | sd_wr;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if ((slot_v && p1_v) || (push_v && fifo_full && !fifo_pop)) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seen <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            seen <= 1'b1;
         end else if (seen && !image_download && !busy) begin
            seen <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_image_sdram_writer.sv
// Self-checking bench for image_sdram_writer: directed scenarios plus
// randomized byte streams compared against a word-level packing model.
module tb_image_sdram_writer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        image_download;
   logic        wr_8bit;
   logic [25:0] addr_8bit;
   logic [7:0]  data_8bit;
   logic        sd_ack;

   logic        sd_wr, busy, overflow, done;
   logic [24:0] sd_addr;
   logic [15:0] sd_data;
   logic        o_sd_wr, o_busy, o_overflow, o_done;
   logic [24:0] o_sd_addr;
   logic [15:0] o_sd_data;

   int n_checks = 0;
   int n_pass   = 0;

   image_sdram_writer #(.FIFO_DEPTH(DEPTH), .SDRAM_BASE(25'h0)) dut (
      .clk(clk), .reset_n(reset_n), .image_download(image_download),
      .wr_8bit(wr_8bit), .addr_8bit(addr_8bit), .data_8bit(data_8bit),
      .sd_wr(sd_wr), .sd_addr(sd_addr), .sd_data(sd_data), .sd_ack(sd_ack),
      .busy(busy), .overflow(overflow), .done(done)
   );

   image_sdram_writer #(.FIFO_DEPTH(DEPTH), .SDRAM_BASE(25'h1000)) dut_off (
      .clk(clk), .reset_n(reset_n), .image_download(image_download),
      .wr_8bit(wr_8bit), .addr_8bit(addr_8bit), .data_8bit(data_8bit),
      .sd_wr(o_sd_wr), .sd_addr(o_sd_addr), .sd_data(o_sd_data), .sd_ack(sd_ack),
      .busy(o_busy), .overflow(o_overflow), .done(o_done)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // SDRAM responder and write/done recorder.
   bit          ack_en    = 1'b0;
   bit          rand_ack  = 1'b0;
   int          ack_delay = 0;
   int          ack_cnt   = 0;
   int          done_cnt  = 0;
   logic [40:0] got_q[$];
   logic [24:0] got_off_q[$];

   initial begin
      sd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (!reset_n) begin
            sd_ack  = 1'b0;
            ack_cnt = 0;
         end else if (sd_ack) begin
            sd_ack  = 1'b0;
            ack_cnt = 0;
         end else if (sd_wr && ack_en) begin
            if (ack_cnt >= ack_delay) begin
               sd_ack = 1'b1;
               got_q.push_back({sd_addr, sd_data});
               got_off_q.push_back(o_sd_addr);
               if (rand_ack) ack_delay = $urandom_range(0, 2);
            end else begin
               ack_cnt++;
            end
         end
      end
   end

   // Word-level reference model: expected {word address, data} in write order.
   bit          m_pend;
   logic [7:0]  m_low;
   logic [24:0] m_wa;
   logic [40:0] exp_q[$];

   function automatic void model_byte(input logic [25:0] a, input logic [7:0] d);
      logic [24:0] w;
      w = a[25:1];
      if (!a[0]) begin
         if (m_pend) exp_q.push_back({m_wa, 8'h00, m_low});
         m_pend = 1'b1;
         m_low  = d;
         m_wa   = w;
      end else begin
         if (m_pend && m_wa == w) begin
            exp_q.push_back({w, d, m_low});
         end else begin
            if (m_pend) exp_q.push_back({m_wa, 8'h00, m_low});
            exp_q.push_back({w, d, 8'h00});
         end
         m_pend = 1'b0;
      end
   endfunction

   task automatic start_download();
      exp_q.delete();
      got_q.delete();
      got_off_q.delete();
      m_pend = 1'b0;
      image_download = 1'b1;
   endtask

   task automatic end_download();
      image_download = 1'b0;
      if (m_pend) exp_q.push_back({m_wa, 8'h00, m_low});
      m_pend = 1'b0;
   endtask

   task automatic send_byte(input logic [25:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_8bit = 1'b1;
      addr_8bit = a;
      data_8bit = d;
      if (image_download) model_byte(a, d);
      @(negedge clk);
      wr_8bit = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int start;
      start = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (sd_wr !== 1'b0) $display("FAIL reset_sd_wr: got %b expected 0", sd_wr); else n_pass++;
      n_checks++; if (sd_addr !== 25'h0) $display("FAIL reset_sd_addr: got %h expected 0", sd_addr); else n_pass++;
      n_checks++; if (sd_data !== 16'h0) $display("FAIL reset_sd_data: got %h expected 0", sd_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_aligned();
      bit ok;
      int lat;
      int d0;
      ack_en = 1'b1; rand_ack = 1'b0; ack_delay = 1;
      d0 = done_cnt;
      start_download();
      send_byte(26'd0, 8'h11);
      send_byte(26'd1, 8'h22);
      lat = 0;
      while (!sd_wr && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      n_checks++; if (lat !== 2) $display("FAIL aligned_latency: got %0d cycles expected 2", lat); else n_pass++;
      send_byte(26'd2, 8'h33);
      send_byte(26'd3, 8'h44);
      end_download();
      wait_done(200, ok);
      n_checks++; if (!ok) $display("FAIL aligned_done_timeout: got none expected done pulse"); else n_pass++;
      n_checks++; if (got_q.size() !== 2) $display("FAIL aligned_count: got %0d expected 2", got_q.size()); else n_pass++;
      n_checks++; if (((got_q.size() > 0) ? got_q[0] : 41'bx) !== {25'h000, 16'h2211})
         $display("FAIL aligned_word0: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 41'bx, {25'h000, 16'h2211}); else n_pass++;
      n_checks++; if (((got_q.size() > 1) ? got_q[1] : 41'bx) !== {25'h001, 16'h4433})
         $display("FAIL aligned_word1: got %h expected %h", (got_q.size() > 1) ? got_q[1] : 41'bx, {25'h001, 16'h4433}); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL aligned_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL aligned_overflow: got %b expected 0", overflow); else n_pass++;
   endtask

   task automatic test_odd_trailing();
      bit ok;
      start_download();
      send_byte(26'd4, 8'hAA);
      end_download();
      wait_done(200, ok);
      n_checks++; if (!ok) $display("FAIL trailing_done_timeout: got none expected done pulse"); else n_pass++;
      n_checks++; if (got_q.size() !== 1) $display("FAIL trailing_count: got %0d expected 1", got_q.size()); else n_pass++;
      n_checks++; if (((got_q.size() > 0) ? got_q[0] : 41'bx) !== {25'h002, 16'h00AA})
         $display("FAIL trailing_word: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 41'bx, {25'h002, 16'h00AA}); else n_pass++;
   endtask

   task automatic test_isolated_odd();
      bit ok;
      start_download();
      send_byte(26'd7, 8'h55);
      end_download();
      wait_done(200, ok);
      n_checks++; if (!ok) $display("FAIL isolated_done_timeout: got none expected done pulse"); else n_pass++;
      n_checks++; if (got_q.size() !== 1) $display("FAIL isolated_count: got %0d expected 1", got_q.size()); else n_pass++;
      n_checks++; if (((got_q.size() > 0) ? got_q[0] : 41'bx) !== {25'h003, 16'h5500})
         $display("FAIL isolated_word: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 41'bx, {25'h003, 16'h5500}); else n_pass++;
   endtask

   task automatic test_address_offset();
      bit ok;
      start_download();
      send_byte(26'h1FE, 8'hAB);
      send_byte(26'h1FF, 8'hCD);
      end_download();
      wait_done(200, ok);
      n_checks++; if (!ok) $display("FAIL offset_done_timeout: got none expected done pulse"); else n_pass++;
      n_checks++; if (((got_q.size() > 0) ? got_q[0] : 41'bx) !== {25'h0FF, 16'hCDAB})
         $display("FAIL offset_base0_word: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 41'bx, {25'h0FF, 16'hCDAB}); else n_pass++;
      n_checks++; if (((got_off_q.size() > 0) ? got_off_q[0] : 25'bx) !== 25'h10FF)
         $display("FAIL offset_base1000_addr: got %h expected 10ff", (got_off_q.size() > 0) ? got_off_q[0] : 25'bx); else n_pass++;
   endtask

   task automatic test_random();
      bit          ok;
      logic [25:0] a;
      logic [25:0] prev;
      logic [24:0] exp_off;
      for (int r = 0; r < 4; r++) begin
         ack_en = 1'b1; rand_ack = 1'b1; ack_delay = $urandom_range(0, 2);
         start_download();
         prev = 26'($urandom_range(0, 15));
         for (int b = 0; b < 16; b++) begin
            if ($urandom_range(0, 1) == 1) a = prev + 26'd1;
            else a = 26'($urandom_range(0, 15));
            prev = a;
            send_byte(a, 8'($urandom));
            repeat (6) @(negedge clk);
         end
         end_download();
         wait_done(400, ok);
         n_checks++; if (!ok) $display("FAIL random_done_timeout round %0d: got none expected done pulse", r); else n_pass++;
         n_checks++; if (got_q.size() !== exp_q.size())
            $display("FAIL random_count round %0d: got %0d expected %0d", r, got_q.size(), exp_q.size()); else n_pass++;
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++; if (((i < got_q.size()) ? got_q[i] : 41'bx) !== exp_q[i])
               $display("FAIL random_word round %0d idx %0d: got %h expected %h", r, i, (i < got_q.size()) ? got_q[i] : 41'bx, exp_q[i]); else n_pass++;
            exp_off = exp_q[i][40:16] + 25'h1000;
            n_checks++; if (((i < got_off_q.size()) ? got_off_q[i] : 25'bx) !== exp_off)
               $display("FAIL random_off_addr round %0d idx %0d: got %h expected %h", r, i, (i < got_off_q.size()) ? got_off_q[i] : 25'bx, exp_off); else n_pass++;
         end
         n_checks++; if (overflow !== 1'b0) $display("FAIL random_overflow round %0d: got %b expected 0", r, overflow); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      bit          ok;
      bit          have;
      bit          stable;
      logic [40:0] held;
      int          n_exp;
      ack_en = 1'b0; rand_ack = 1'b0; ack_delay = 0;
      have = 1'b0; stable = 1'b1; held = '0;
      start_download();
      for (int i = 0; i < 2 * (DEPTH + 2); i++) begin
         send_byte(26'h40 + 26'(i), 8'($urandom));
         if (have) begin
            if (!sd_wr || {sd_addr, sd_data} != held) stable = 1'b0;
         end else if (sd_wr) begin
            have = 1'b1;
            held = {sd_addr, sd_data};
         end
      end
      repeat (4) @(negedge clk);
      if (have && (!sd_wr || {sd_addr, sd_data} != held)) stable = 1'b0;
      n_checks++; if (have !== 1'b1) $display("FAIL bp_request_seen: got %b expected 1", have); else n_pass++;
      n_checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable); else n_pass++;
      n_checks++; if (held !== exp_q[0]) $display("FAIL bp_held_word: got %h expected %h", held, exp_q[0]); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b expected 1", overflow); else n_pass++;
      n_checks++; if (o_overflow !== 1'b1) $display("FAIL bp_overflow_off: got %b expected 1", o_overflow); else n_pass++;
      end_download();
      ack_en = 1'b1;
      wait_done(400, ok);
      n_exp = (exp_q.size() < DEPTH + 1) ? exp_q.size() : DEPTH + 1;
      n_checks++; if (!ok) $display("FAIL bp_done_timeout: got none expected done pulse"); else n_pass++;
      n_checks++; if (got_q.size() !== DEPTH + 1) $display("FAIL bp_count: got %0d expected %0d", got_q.size(), DEPTH + 1); else n_pass++;
      for (int i = 0; i < n_exp; i++) begin
         n_checks++; if (((i < got_q.size()) ? got_q[i] : 41'bx) !== exp_q[i])
            $display("FAIL bp_word idx %0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 41'bx, exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      ack_en = 1'b0; rand_ack = 1'b0; ack_delay = 0;
      start_download();
      for (int i = 0; i < 8; i++) send_byte(26'h80 + 26'(i), 8'($urandom));
      repeat (3) @(negedge clk);
      n_checks++; if (sd_wr !== 1'b1) $display("FAIL rstmid_pre_sd_wr: got %b expected 1", sd_wr); else n_pass++;
      reset_n = 1'b0;
      image_download = 1'b0;
      @(negedge clk);
      n_checks++; if (sd_wr !== 1'b0) $display("FAIL rstmid_sd_wr: got %b expected 0", sd_wr); else n_pass++;
      n_checks++; if (sd_addr !== 25'h0) $display("FAIL rstmid_sd_addr: got %h expected 0", sd_addr); else n_pass++;
      n_checks++; if (sd_data !== 16'h0) $display("FAIL rstmid_sd_data: got %h expected 0", sd_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b expected 0", overflow); else n_pass++;
      n_checks++; if (o_sd_addr !== 25'h0) $display("FAIL rstmid_off_addr: got %h expected 0", o_sd_addr); else n_pass++;
      reset_n = 1'b1;
      got_q.delete();
      ack_en = 1'b1;
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      n_checks++; if (got_q.size() !== 0) $display("FAIL rstmid_writes_after: got %0d expected 0", got_q.size()); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 0) $display("FAIL rstmid_done: got %0d expected 0", done_cnt - d0); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b expected 0", busy); else n_pass++;
   endtask

   initial begin
      reset_n        = 1'b0;
      image_download = 1'b0;
      wr_8bit        = 1'b0;
      addr_8bit      = '0;
      data_8bit      = '0;
      test_reset();
      test_aligned();
      test_odd_trailing();
      test_isolated_odd();
      test_address_offset();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
